// File: rtl/fifo_pkg.sv
// Shared async-FIFO types and Gray/binary helpers used by both pointer controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 9;

  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[FIFO_ADDR_WIDTH] = gray[FIFO_ADDR_WIDTH];
    for (int i = int'(FIFO_ADDR_WIDTH) - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
module gray2bin_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    o_bin[WIDTH-1] = i_gray[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      o_bin[i] = o_bin[i+1] ^ i_gray[i];
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full and occupancy controller for the async FIFO.
// Optional sticky overflow flag enabled by WPTR_OVERFLOW_FLAG_EN.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic                  i_winc,
  input  logic [ADDR_WIDTH:0]   i_wq2_rptr,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH:0]   o_wptr,
  output logic                  o_wfull,
  output logic                  o_walmost_full,
  output logic [ADDR_WIDTH:0]   o_wcount
`ifdef WPTR_OVERFLOW_FLAG_EN
  ,
  output logic                  o_woverflow
`endif
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDR_WIDTH:0] r_wbin;
  logic [ADDR_WIDTH:0] r_wptr;
  logic                r_wfull;
  logic                r_walmost_full;
  logic [ADDR_WIDTH:0] r_wcount;

  logic                w_wpush;
  logic [ADDR_WIDTH:0] w_wbinnext;
  logic [ADDR_WIDTH:0] w_wgraynext;
  logic [ADDR_WIDTH:0] w_rbin;
  logic [ADDR_WIDTH:0] w_wcount_next;
  logic                w_wfull_next;
  logic                w_walmost_full_next;

  gray2bin_conv #(
    .WIDTH (PW)
  ) u_rptr_g2b (
    .i_gray (i_wq2_rptr),
    .o_bin  (w_rbin)
  );

  assign w_wpush     = i_winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + PW'(w_wpush);
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Full when the write pointer has lapped the read pointer by exactly one depth.
  assign w_wfull_next = (w_wgraynext ==
                         {~i_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], i_wq2_rptr[ADDR_WIDTH-2:0]});

  assign w_wcount_next       = w_wbinnext - w_rbin;
  assign w_walmost_full_next = (w_wcount_next >= AFULL_LEVEL);

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wcount       <= '0;
    end else begin
      r_wbin         <= w_wbinnext;
      r_wptr         <= w_wgraynext;
      r_wfull        <= w_wfull_next;
      r_walmost_full <= w_walmost_full_next;
      r_wcount       <= w_wcount_next;
    end
  end

`ifdef WPTR_OVERFLOW_FLAG_EN
  logic r_woverflow;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      r_woverflow <= 1'b0;
    end else begin
      r_woverflow <= r_woverflow | (i_winc & r_wfull);
    end
  end

  assign o_woverflow = r_woverflow;
`endif

  assign o_waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign o_wptr         = r_wptr;
  assign o_wfull        = r_wfull;
  assign o_walmost_full = r_walmost_full;
  assign o_wcount       = r_wcount;

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and status controller for the asynchronous FIFO. Keeps the binary write counter that addresses the dual-port FIFO memory and the Gray-coded write pointer that the read domain synchronises. Compares its next pointer against the read pointer, already synchronised into the write clock, to produce full, almost-full, occupancy and an optional overflow flag. It sits directly upstream of the memory, driving its `waddr` and `wfull` inputs.

## Interface
- `ADDR_WIDTH`, 9: memory address bits. Depth is DEPTH = 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- `AFULL_MARGIN`, 4: `walmost_full` asserts when occupancy ≥ DEPTH − AFULL_MARGIN. Legal range is 1..DEPTH−1.
- `wclk`, in, 1: write clock. This is the only clock.
- `wrst_n`, in, 1: asynchronous, active-low reset.
- `winc`, in, 1: write request from the producer.
- `wq2_rptr`, in, ADDR_WIDTH+1: Gray read pointer, already double-synchronised into `wclk`.
- `waddr`, out, ADDR_WIDTH: memory write address, equal to `wbin[ADDR_WIDTH-1:0]`.
- `wptr`, out, ADDR_WIDTH+1: registered Gray write pointer, sent to the read-domain synchroniser.
- `wfull`, out, 1: registered full flag.
- `walmost_full`, out, 1: registered almost-full flag.
- `wcount`, out, ADDR_WIDTH+1: registered occupancy, range 0..DEPTH.
- `woverflow`, out, 1: sticky overflow flag. Present only with `WPTR_OVERFLOW_FLAG_EN`.

## Operation
- Accepted write: `wpush = winc & ~wfull`.
- Next binary pointer: `wbinnext = wbin + wpush`, modulo 2^(ADDR_WIDTH+1).
- Next Gray pointer: `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- Full term: `wfull_next = (wgraynext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]})`.
- Occupancy:
  - `rbin = gray2bin(wq2_rptr)`.
  - `wcount_next = wbinnext − rbin`, modulo 2^(ADDR_WIDTH+1).
  - `walmost_full_next = (wcount_next ≥ DEPTH − AFULL_MARGIN)`.
- All of `wbin`, `wptr`, `wfull`, `walmost_full`, `wcount` and `woverflow` are flops. `waddr` is a direct slice of `wbin` with no extra logic.
- Status is pessimistic. `wq2_rptr` lags the true read pointer by 2 or more cycles, so full and almost-full can stay asserted late, but are never deasserted early.
- No state machine; the block is a counter plus registered compare.

## Timing
- Reset, asynchronous assert: `wbin`=0, `wptr`=0, `waddr`=0, `wfull`=0, `walmost_full`=0, `wcount`=0, `woverflow`=0. Release is synchronous to `wclk` by upstream reset logic.
- Write latency: `winc` sampled high at edge N means the memory writes `mem[waddr]` at edge N. `waddr`, `wptr` and `wcount` advance after edge N.
- Full latency: the write that fills the FIFO asserts `wfull` after that same edge, so the next cycle's `winc` is blocked.
- Read-side release: a change on `wq2_rptr` is reflected in `wfull`, `walmost_full` and `wcount` one edge later.
- `winc` while `wfull`=1 is ignored. The pointers hold, and the memory is already gated by `wfull`.
- Simultaneous push and read-pointer advance: both apply in the same `wcount_next` evaluation, and the net occupancy is unchanged.
- Wrap-around: `wbin` rolls from 2^(ADDR_WIDTH+1)−1 to 0, and `wptr` rolls from the Gray MSB-only code to 0. Flags are unaffected.
- Reset mid-operation: all state clears immediately. Coordinating reset with the read domain is out of scope.

## Configuration
- Macro: `WPTR_OVERFLOW_FLAG_EN`.
- Defined: the `woverflow` port exists. It sets on any edge where `winc & wfull`, and it stays set until `wrst_n` is asserted.
- Undefined: the port and its flop are absent. Overflow attempts are silently dropped.

## Structure
- Package `fifo_pkg` holds:
  - the default `ADDR_WIDTH`;
  - `ptr_t`, an ADDR_WIDTH+1 bit vector;
  - the functions `bin2gray` and `gray2bin`.
- Sub-module `gray2bin_conv` is a parameterised combinational prefix-XOR converter. It is instantiated for `wq2_rptr` and reused by the read-side controller.

## Test plan
All scenarios use ADDR_WIDTH=2 and AFULL_MARGIN=1.
- Reset: pull `wrst_n` low after 3 writes → all outputs read 0 within the same cycle, with no clock edge needed.
- Fill: `wq2_rptr`=000, 4 pushes → `waddr` steps 0,1,2,3 and `wptr` steps 000,001,011,010,110. `wfull`=1 the cycle after the 4th push, with `wcount`=4.
- Almost-full: from empty, 3 pushes → `walmost_full` rises with `wcount`=3. `wfull` stays 0.
- Overflow: a 5th `winc` while full → `wptr` holds at 110 and `waddr`=0. `woverflow`=1 next cycle and stays 1, only with the macro defined.
- Release: from full, `wq2_rptr` changes 000→001 → `wfull`=0 and `wcount`=3 one edge later. The next push is accepted at `waddr`=0.
- Wrap: `wq2_rptr` tracks `wptr` with a 2-cycle lag over 9 pushes → `wbin` wraps 111→000 and `wptr` wraps 100→000. `wfull` is never asserted.
